rs_issue_sched: RTL and testbench

Issue scheduler for the out-of-order core's unified reservation station. It tracks source-operand readiness for up to RS_ENTRIES in-flight uops. It allocates entries from the dispatch stage, wakes operands on writeback tag broadcasts, and selects the oldest ready uop per execution pipe (ALU_LOWER, ALU_UPPER, MUL, LSU) under a valid/ready handshake. The uop payload lives in a separate RS data array indexed by the granted entry number; this block holds only tags, readiness, pipe and age state.

---
 rtl/rs_issue_sched.sv | 211 +++++++++++++++++++++
 tb/tb_rs_issue_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: tracks operand readiness and age, picks the oldest ready uop per pipe.
// Define RS_B2B_ISSUE_EN to let same-cycle wakeups reach select (back-to-back issue).
module rs_issue_sched #(
   parameter int unsigned RS_ENTRIES   = 8,
   parameter int unsigned NUM_PREGS    = 128,
   parameter int unsigned NUM_FUS      = 4,
   parameter int unsigned DISP_WIDTH   = 2,
   parameter int unsigned NUM_ROB_ENTS = 64,
   localparam int unsigned PW = $clog2(NUM_PREGS),
   localparam int unsigned RW = $clog2(NUM_ROB_ENTS),
   localparam int unsigned EW = $clog2(RS_ENTRIES),
   localparam int unsigned CW = $clog2(RS_ENTRIES + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [DISP_WIDTH-1:0]      disp_valid,
   output logic                       disp_ready,
   input  logic [DISP_WIDTH*PW-1:0]   disp_src1_tag,
   input  logic [DISP_WIDTH*PW-1:0]   disp_src2_tag,
   input  logic [DISP_WIDTH-1:0]      disp_src1_rdy,
   input  logic [DISP_WIDTH-1:0]      disp_src2_rdy,
   input  logic [DISP_WIDTH*2-1:0]    disp_pipe,
   input  logic [DISP_WIDTH*RW-1:0]   disp_rob_idx,
   output logic [DISP_WIDTH*EW-1:0]   disp_entry,
   input  logic [NUM_FUS-1:0]         wk_valid,
   input  logic [NUM_FUS*PW-1:0]      wk_tag,
   output logic [NUM_FUS-1:0]         iss_valid,
   input  logic [NUM_FUS-1:0]         iss_ready,
   output logic [NUM_FUS*EW-1:0]      iss_entry,
   output logic [NUM_FUS*RW-1:0]      iss_rob_idx,
   output logic [CW-1:0]              free_count
);

   logic [RS_ENTRIES-1:0] valid_q, valid_d;
   logic [PW-1:0]         src1_tag_q [RS_ENTRIES];
   logic [PW-1:0]         src1_tag_d [RS_ENTRIES];
   logic [PW-1:0]         src2_tag_q [RS_ENTRIES];
   logic [PW-1:0]         src2_tag_d [RS_ENTRIES];
   logic [RS_ENTRIES-1:0] src1_rdy_q, src1_rdy_d;
   logic [RS_ENTRIES-1:0] src2_rdy_q, src2_rdy_d;
   logic [1:0]            pipe_q [RS_ENTRIES];
   logic [1:0]            pipe_d [RS_ENTRIES];
   logic [RW-1:0]         rob_q [RS_ENTRIES];
   logic [RW-1:0]         rob_d [RS_ENTRIES];
   logic [RS_ENTRIES-1:0] age_q [RS_ENTRIES];
   logic [RS_ENTRIES-1:0] age_d [RS_ENTRIES];
   logic [CW-1:0]         free_count_q, free_count_d;

   logic [RS_ENTRIES-1:0] wk_hit1, wk_hit2;
   logic [RS_ENTRIES-1:0] sel_rdy;
   logic [RS_ENTRIES-1:0] cand [NUM_FUS];
   logic [EW-1:0]         gnt_idx [NUM_FUS];
   logic [NUM_FUS-1:0]    cand_any;
   logic [NUM_FUS-1:0]    iss_hs;
   logic [EW-1:0]         alloc_idx [DISP_WIDTH];
   logic [DISP_WIDTH-1:0] disp_acc;

   // Wakeup hits against the registered source tags
   always_comb begin
      wk_hit1 = '0;
      wk_hit2 = '0;
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
         for (int unsigned f = 0; f < NUM_FUS; f++) begin
            if (wk_valid[f] && (wk_tag[f*PW +: PW] == src1_tag_q[i])) wk_hit1[i] = 1'b1;
            if (wk_valid[f] && (wk_tag[f*PW +: PW] == src2_tag_q[i])) wk_hit2[i] = 1'b1;
         end
      end
   end

   always_comb begin
`ifdef RS_B2B_ISSUE_EN
      sel_rdy = (src1_rdy_q | wk_hit1) & (src2_rdy_q | wk_hit2);
`else
      sel_rdy = src1_rdy_q & src2_rdy_q;
`endif
   end

   // Oldest-first select: grant the candidate with no older candidate in the same pipe
   always_comb begin
      logic older;
      older = 1'b0;
      for (int unsigned p = 0; p < NUM_FUS; p++) begin
         cand[p]    = '0;
         gnt_idx[p] = '0;
         for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            cand[p][i] = valid_q[i] && sel_rdy[i] && (pipe_q[i] == 2'(p));
         end
         cand_any[p] = |cand[p];
         for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (cand[p][i]) begin
               older = 1'b0;
               for (int unsigned j = 0; j < RS_ENTRIES; j++) begin
                  if (cand[p][j] && age_q[j][i]) older = 1'b1;
               end
               if (!older) gnt_idx[p] = EW'(i);
            end
         end
      end
   end

   always_comb begin
      iss_valid = cand_any & {NUM_FUS{!flush && !rst}};
      iss_hs    = iss_valid & iss_ready;
      for (int unsigned p = 0; p < NUM_FUS; p++) begin
         iss_entry[p*EW +: EW]   = iss_valid[p] ? gnt_idx[p] : '0;
         iss_rob_idx[p*RW +: RW] = iss_valid[p] ? rob_q[gnt_idx[p]] : '0;
      end
   end

   // Slot s takes the (s+1)-th lowest free entry, whether or not lower slots dispatch
   always_comb begin
      int unsigned cnt;
      cnt = 0;
      for (int unsigned s = 0; s < DISP_WIDTH; s++) alloc_idx[s] = '0;
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
         if (!valid_q[i]) begin
            for (int unsigned s = 0; s < DISP_WIDTH; s++) begin
               if (cnt == s) alloc_idx[s] = EW'(i);
            end
            cnt++;
         end
      end
      for (int unsigned s = 0; s < DISP_WIDTH; s++) disp_entry[s*EW +: EW] = alloc_idx[s];
      disp_ready = (free_count_q >= CW'(DISP_WIDTH)) && !flush && !rst;
      disp_acc   = disp_valid & {DISP_WIDTH{disp_ready}};
   end

   always_comb begin
      logic [CW-1:0] acc_cnt;
      logic [CW-1:0] hs_cnt;
      logic          r1, r2;
      logic [EW-1:0] e;
      valid_d      = valid_q;
      src1_tag_d   = src1_tag_q;
      src2_tag_d   = src2_tag_q;
      src1_rdy_d   = src1_rdy_q | (wk_hit1 & valid_q);
      src2_rdy_d   = src2_rdy_q | (wk_hit2 & valid_q);
      pipe_d       = pipe_q;
      rob_d        = rob_q;
      age_d        = age_q;
      acc_cnt      = '0;
      hs_cnt       = '0;
      r1           = 1'b0;
      r2           = 1'b0;
      e            = '0;
      for (int unsigned p = 0; p < NUM_FUS; p++) begin
         if (iss_hs[p]) valid_d[gnt_idx[p]] = 1'b0;
         hs_cnt = hs_cnt + CW'(iss_hs[p]);
      end
      // New entries are younger than every pre-edge valid entry and than lower slots
      for (int unsigned s = 0; s < DISP_WIDTH; s++) begin
         if (disp_acc[s]) begin
            e  = alloc_idx[s];
            r1 = disp_src1_rdy[s];
            r2 = disp_src2_rdy[s];
            for (int unsigned f = 0; f < NUM_FUS; f++) begin
               if (wk_valid[f] && (wk_tag[f*PW +: PW] == disp_src1_tag[s*PW +: PW])) r1 = 1'b1;
               if (wk_valid[f] && (wk_tag[f*PW +: PW] == disp_src2_tag[s*PW +: PW])) r2 = 1'b1;
            end
            valid_d[e]    = 1'b1;
            src1_tag_d[e] = disp_src1_tag[s*PW +: PW];
            src2_tag_d[e] = disp_src2_tag[s*PW +: PW];
            src1_rdy_d[e] = r1;
            src2_rdy_d[e] = r2;
            pipe_d[e]     = disp_pipe[s*2 +: 2];
            rob_d[e]      = disp_rob_idx[s*RW +: RW];
            age_d[e]      = '0;
            for (int unsigned j = 0; j < RS_ENTRIES; j++) age_d[j][e] = valid_q[j];
            for (int unsigned t = 0; t < s; t++) begin
               if (disp_acc[t]) age_d[alloc_idx[t]][e] = 1'b1;
            end
            acc_cnt = acc_cnt + 1'b1;
         end
      end
      free_count_d = free_count_q - acc_cnt + hs_cnt;
      if (flush) begin
         valid_d      = '0;
         free_count_d = CW'(RS_ENTRIES);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         src1_rdy_q   <= '0;
         src2_rdy_q   <= '0;
         free_count_q <= CW'(RS_ENTRIES);
         for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            src1_tag_q[i] <= '0;
            src2_tag_q[i] <= '0;
            pipe_q[i]     <= '0;
            rob_q[i]      <= '0;
            age_q[i]      <= '0;
         end
      end else begin
         valid_q      <= valid_d;
         src1_tag_q   <= src1_tag_d;
         src2_tag_q   <= src2_tag_d;
         src1_rdy_q   <= src1_rdy_d;
         src2_rdy_q   <= src2_rdy_d;
         pipe_q       <= pipe_d;
         rob_q        <= rob_d;
         age_q        <= age_d;
         free_count_q <= free_count_d;
      end
   end

   assign free_count = free_count_q;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Scoreboarded directed bench for rs_issue_sched; issue handshakes are checked in order by a monitor.
module tb_rs_issue_sched;
   localparam int unsigned PW = 7;
   localparam int unsigned RW = 6;
   localparam int unsigned EW = 3;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst, flush;
   logic [1:0]    disp_valid;
   logic          disp_ready;
   logic [2*PW-1:0] disp_src1_tag, disp_src2_tag;
   logic [1:0]    disp_src1_rdy, disp_src2_rdy;
   logic [3:0]    disp_pipe;
   logic [2*RW-1:0] disp_rob_idx;
   logic [2*EW-1:0] disp_entry;
   logic [3:0]    wk_valid;
   logic [4*PW-1:0] wk_tag;
   logic [3:0]    iss_valid, iss_ready;
   logic [4*EW-1:0] iss_entry;
   logic [4*RW-1:0] iss_rob_idx;
   logic [CW-1:0] free_count;

   rs_issue_sched #(
      .RS_ENTRIES(8), .NUM_PREGS(128), .NUM_FUS(4), .DISP_WIDTH(2), .NUM_ROB_ENTS(64)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_pipe(disp_pipe), .disp_rob_idx(disp_rob_idx), .disp_entry(disp_entry),
      .wk_valid(wk_valid), .wk_tag(wk_tag),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_entry(iss_entry), .iss_rob_idx(iss_rob_idx), .free_count(free_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    pipe;
      logic [EW-1:0] entry;
      logic [RW-1:0] rob;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int pipe, input int entry, input int rob);
      exp_t e;
      e.pipe  = 2'(pipe);
      e.entry = EW'(entry);
      e.rob   = RW'(rob);
      exp_q.push_back(e);
   endtask

   // Monitor: every issue handshake must match the next expected grant
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         for (int p = 0; p < 4; p++) begin
            if (iss_valid[p] && iss_ready[p]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_issue: pipe %0d entry %0d, expected no issue", p, iss_entry[p*EW +: EW]);
               end else begin
                  e = exp_q.pop_front();
                  chk("issue_pipe", p, e.pipe);
                  chk("issue_entry", iss_entry[p*EW +: EW], e.entry);
                  chk("issue_rob", iss_rob_idx[p*RW +: RW], e.rob);
               end
            end
         end
      end
   end

   task automatic clr();
      disp_valid    = '0;
      disp_src1_tag = '0;
      disp_src2_tag = '0;
      disp_src1_rdy = '0;
      disp_src2_rdy = '0;
      disp_pipe     = '0;
      disp_rob_idx  = '0;
      wk_valid      = '0;
      wk_tag        = '0;
      flush         = 1'b0;
   endtask

   task automatic slot(input int s, input int pipe, input int t1, input bit r1,
                       input int t2, input bit r2, input int rob);
      disp_valid[s]               = 1'b1;
      disp_src1_tag[s*PW +: PW]   = PW'(t1);
      disp_src2_tag[s*PW +: PW]   = PW'(t2);
      disp_src1_rdy[s]            = r1;
      disp_src2_rdy[s]            = r2;
      disp_pipe[s*2 +: 2]         = 2'(pipe);
      disp_rob_idx[s*RW +: RW]    = RW'(rob);
   endtask

   task automatic wake(input int f, input int tag);
      wk_valid[f]         = 1'b1;
      wk_tag[f*PW +: PW]  = PW'(tag);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      iss_ready = '0;
      clr();
      nxt();
      nxt();
      smp();
      chk("rst_iss_valid", iss_valid, 0);
      nxt();
      rst = 1'b0;
      smp();
      chk("reset_free_count", free_count, 8);
      chk("reset_disp_ready", disp_ready, 1);
      chk("reset_iss_valid", iss_valid, 0);
      chk("reset_iss_entry", iss_entry, 0);
      chk("reset_iss_rob", iss_rob_idx, 0);

      // Two ready ALU_LOWER uops
      nxt(); clr(); iss_ready = 4'b0001;
      slot(0, 0, 1, 1, 2, 1, 10);
      slot(1, 0, 3, 1, 4, 1, 11);
      push(0, 0, 10); push(0, 1, 11);
      smp();
      chk("alloc_slot0", disp_entry[0 +: EW], 0);
      chk("alloc_slot1", disp_entry[EW +: EW], 1);
      chk("no_issue_same_cycle", iss_valid, 0);
      nxt(); clr(); smp();
      chk("alu_iss_valid", iss_valid[0], 1);
      chk("alu_first_entry", iss_entry[0 +: EW], 0);
      chk("alu_free_after_disp", free_count, 6);
      nxt(); clr(); smp();
      chk("alu_second_entry", iss_entry[0 +: EW], 1);
      chk("alu_free_after_one", free_count, 7);
      nxt(); clr(); iss_ready = '0; smp();
      chk("alu_free_restored", free_count, 8);
      chk("alu_drained", iss_valid, 0);

      // MUL uop waiting on p37
      nxt(); clr(); slot(0, 2, 37, 0, 5, 1, 20); push(2, 0, 20); smp();
      nxt(); clr(); smp();
      chk("mul_not_ready", iss_valid[2], 0);
      nxt(); clr(); wake(0, 37); iss_ready = 4'b0100; smp();
`ifdef RS_B2B_ISSUE_EN
      chk("mul_b2b_valid", iss_valid[2], 1);
      chk("mul_b2b_entry", iss_entry[2*EW +: EW], 0);
`else
      chk("mul_wake_cycle_idle", iss_valid[2], 0);
`endif
      nxt(); clr(); smp();
`ifdef RS_B2B_ISSUE_EN
      chk("mul_issued_gone", iss_valid[2], 0);
`else
      chk("mul_next_valid", iss_valid[2], 1);
      chk("mul_next_entry", iss_entry[2*EW +: EW], 0);
`endif
      nxt(); clr(); iss_ready = '0; smp();
      chk("mul_free_restored", free_count, 8);

      // Same-cycle wakeup at dispatch
      nxt(); clr(); slot(0, 0, 55, 0, 6, 1, 40); wake(3, 55); push(0, 0, 40); smp();
      chk("disp_wake_not_same_cycle", iss_valid, 0);
      nxt(); clr(); iss_ready = 4'b0001; smp();
      chk("disp_wake_valid", iss_valid[0], 1);
      chk("disp_wake_entry", iss_entry[0 +: EW], 0);
      nxt(); clr(); iss_ready = '0; smp();
      chk("disp_wake_free", free_count, 8);

      // LSU A,B then C on slot 1 alone; consumer stalls three cycles
      nxt(); clr();
      slot(0, 3, 7, 1, 8, 1, 50);
      slot(1, 3, 9, 1, 10, 1, 51);
      push(3, 0, 50); push(3, 1, 51);
      smp();
      nxt(); clr(); slot(1, 3, 11, 1, 12, 1, 52); push(3, 3, 52); smp();
      chk("slot1_alone_entry", disp_entry[EW +: EW], 3);
      chk("lsu_valid", iss_valid[3], 1);
      chk("lsu_hold0", iss_entry[3*EW +: EW], 0);
      nxt(); clr(); smp();
      chk("lsu_hold1", iss_entry[3*EW +: EW], 0);
      chk("lsu_hold1_rob", iss_rob_idx[3*RW +: RW], 50);
      chk("lsu_free", free_count, 5);
      nxt(); clr(); smp();
      chk("lsu_hold2", iss_entry[3*EW +: EW], 0);
      nxt(); clr(); iss_ready = 4'b1000; smp();
      nxt(); clr(); smp();
      nxt(); clr(); smp();
      nxt(); clr(); iss_ready = '0; smp();
      chk("lsu_free_restored", free_count, 8);
      chk("lsu_drained", iss_valid, 0);

      // Fill with waiting ALU_UPPER uops (src1 tag 100+k for entry k)
      for (int k = 0; k < 3; k++) begin
         nxt(); clr();
         slot(0, 1, 100 + 2*k, 0, 1, 1, 60 + 2*k);
         slot(1, 1, 101 + 2*k, 0, 1, 1, 61 + 2*k);
         smp();
      end
      nxt(); clr(); slot(0, 1, 106, 0, 1, 1, 66); smp();
      chk("fill_free2", free_count, 2);
      chk("fill_ready_at2", disp_ready, 1);
      nxt(); clr(); slot(1, 1, 107, 0, 1, 1, 67); smp();
      chk("full_free1", free_count, 1);
      chk("full_not_ready", disp_ready, 0);
      nxt(); clr(); wake(0, 100); wake(1, 101); push(1, 0, 60); push(1, 1, 61); smp();
      chk("full_rejected", free_count, 1);
      nxt(); clr(); iss_ready = 4'b0010; smp();
      chk("full_iss_valid", iss_valid[1], 1);
      chk("full_iss_entry", iss_entry[EW +: EW], 0);
      nxt(); clr(); smp();
      chk("after_issue_free2", free_count, 2);
      chk("after_issue_ready", disp_ready, 1);
      chk("after_issue_entry", iss_entry[EW +: EW], 1);
      nxt(); clr(); iss_ready = '0; wake(2, 102); smp();
      chk("five_valid_free3", free_count, 3);

      // Flush with a ready candidate and every pipe accepting
      nxt(); clr(); flush = 1'b1; iss_ready = '1; smp();
      chk("flush_iss_valid", iss_valid, 0);
      chk("flush_disp_ready", disp_ready, 0);
      nxt(); clr(); smp();
      chk("flush_free", free_count, 8);
      chk("flush_empty", iss_valid, 0);

      // Reset mid-operation with a ready entry
      nxt(); clr(); iss_ready = '0; slot(0, 0, 1, 1, 1, 1, 70); smp();
      nxt(); clr(); rst = 1'b1; iss_ready = '1; smp();
      chk("midrst_iss_valid", iss_valid, 0);
      nxt(); rst = 1'b0; iss_ready = '0; smp();
      chk("midrst_free", free_count, 8);
      chk("midrst_empty", iss_valid, 0);

      nxt(); smp();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
